dtree_seq_engine: RTL and testbench

- Sequential, programmable decision-tree classifier; successor to the fixed, fully combinational per-dataset tree blocks.
- Walks one tree node per clock from a loadable node table, so a single instance serves any tree up to N_NODES nodes.
- Sits between the feature-capture front end and the class-output/voting logic, with valid/ready handshakes on both sides.
- Adds behaviour the fixed trees lack: runtime tree programming, node-level MSB truncation (shifted comparisons), step-limit timeout and error flagging.

---
 rtl/dtree_seq_engine.sv | 187 ++++++++++++++++++
 tb/tb_dtree_seq_engine.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/dtree_seq_engine.sv
// Programmable decision-tree classifier: walks one node per clock from a
// loadable node table, with valid/ready handshakes on the feature and result sides.
module dtree_seq_engine #(
  parameter int unsigned N_FEAT    = 8,
  parameter int unsigned FEAT_W    = 8,
  parameter int unsigned CLASS_W   = 5,
  parameter int unsigned N_NODES   = 32,
  parameter int unsigned MAX_STEPS = 16,
  localparam int unsigned FIDX_W   = (N_FEAT > 1) ? $clog2(N_FEAT) : 1,
  localparam int unsigned SH_W     = (FEAT_W > 1) ? $clog2(FEAT_W) : 1,
  localparam int unsigned ADDR_W   = (N_NODES > 1) ? $clog2(N_NODES) : 1,
  localparam int unsigned NODE_W   = 1 + FIDX_W + SH_W + FEAT_W + 2 * ADDR_W,
  localparam int unsigned STEP_W   = $clog2(MAX_STEPS + 1)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       cfg_we,
  input  logic [ADDR_W-1:0]          cfg_addr,
  input  logic [NODE_W-1:0]          cfg_data,
  output logic                       cfg_ready,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [N_FEAT*FEAT_W-1:0]   in_feat,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [CLASS_W-1:0]         out_class,
  output logic [STEP_W-1:0]          out_steps,
  output logic                       out_err
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WALK = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  // Feature slots are padded to the full index range; slots past N_FEAT are flagged bad.
  localparam int unsigned FIDX_N = 1 << FIDX_W;
  localparam logic [FIDX_N-1:0] FEAT_OK = FIDX_N'((64'd1 << N_FEAT) - 64'd1);
  localparam logic [NODE_W-1:0] NODE_RST = {1'b1, (NODE_W-1)'(0)};

  logic [1:0]          r_state;
  logic [ADDR_W-1:0]   r_ptr;
  logic [STEP_W-1:0]   r_steps;
  logic [FEAT_W-1:0]   r_feat [FIDX_N];
  logic [NODE_W-1:0]   r_tbl  [N_NODES];
  logic                r_rdy;
  logic                r_out_valid;
  logic [CLASS_W-1:0]  r_out_class;
  logic [STEP_W-1:0]   r_out_steps;
  logic                r_out_err;

  logic [FEAT_W-1:0]   w_feat_in [FIDX_N];
  logic [NODE_W-1:0]   w_node;
  logic                w_leaf;
  logic [FIDX_W-1:0]   w_fidx;
  logic [SH_W-1:0]     w_shift;
  logic [FEAT_W-1:0]   w_thr;
  logic [ADDR_W-1:0]   w_left;
  logic [ADDR_W-1:0]   w_right;
  logic [FEAT_W-1:0]   w_fsh;
  logic                w_le;
  logic                w_bad_fidx;
  logic                w_timeout;

  logic [1:0]          w_state_nxt;
  logic [ADDR_W-1:0]   w_ptr_nxt;
  logic [STEP_W-1:0]   w_steps_nxt;
  logic                w_rdy_nxt;
  logic                w_valid_nxt;
  logic [CLASS_W-1:0]  w_class_nxt;
  logic [STEP_W-1:0]   w_osteps_nxt;
  logic                w_err_nxt;
  logic                w_tbl_we;
  logic                w_feat_ld;

  for (genvar k = 0; k < FIDX_N; k++) begin : g_feat
    if (k < N_FEAT) begin : g_real
      assign w_feat_in[k] = in_feat[k*FEAT_W +: FEAT_W];
    end else begin : g_pad
      assign w_feat_in[k] = '0;
    end
  end

  // Node decode: {leaf, fidx, shift, thr, left, right}, MSB first.
  assign w_node     = r_tbl[r_ptr];
  assign w_leaf     = w_node[NODE_W-1];
  assign w_fidx     = w_node[NODE_W-2 -: FIDX_W];
  assign w_shift    = w_node[NODE_W-2-FIDX_W -: SH_W];
  assign w_thr      = w_node[2*ADDR_W +: FEAT_W];
  assign w_left     = w_node[ADDR_W +: ADDR_W];
  assign w_right    = w_node[0 +: ADDR_W];
  assign w_fsh      = r_feat[w_fidx] >> w_shift;
  assign w_le       = (w_fsh <= w_thr);
  assign w_bad_fidx = ~FEAT_OK[w_fidx];
  assign w_timeout  = (r_steps == STEP_W'(MAX_STEPS - 1));

  // Next-state and next-output logic.
  always_comb begin
    w_state_nxt  = r_state;
    w_ptr_nxt    = r_ptr;
    w_steps_nxt  = r_steps;
    w_valid_nxt  = r_out_valid;
    w_class_nxt  = r_out_class;
    w_osteps_nxt = r_out_steps;
    w_err_nxt    = r_out_err;
    w_tbl_we     = 1'b0;
    w_feat_ld    = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_tbl_we = cfg_we;
        if (in_valid) begin
          w_feat_ld   = 1'b1;
          w_ptr_nxt   = '0;
          w_steps_nxt = '0;
          w_state_nxt = S_WALK;
        end
      end
      S_WALK: begin
        w_steps_nxt = r_steps + STEP_W'(1);
        // Leaf wins over a bad index, which wins over timeout; both errors report class 0.
        if (w_leaf || w_bad_fidx || w_timeout) begin
          w_state_nxt  = S_DONE;
          w_valid_nxt  = 1'b1;
          w_osteps_nxt = r_steps + STEP_W'(1);
          w_err_nxt    = ~w_leaf;
          w_class_nxt  = w_leaf ? w_thr[CLASS_W-1:0] : '0;
        end else begin
          w_ptr_nxt = w_le ? w_left : w_right;
        end
      end
      S_DONE: begin
        if (out_ready) begin
          w_state_nxt = S_IDLE;
          w_valid_nxt = 1'b0;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
    w_rdy_nxt = (w_state_nxt == S_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_ptr       <= '0;
      r_steps     <= '0;
      r_rdy       <= 1'b1;
      r_out_valid <= 1'b0;
      r_out_class <= '0;
      r_out_steps <= '0;
      r_out_err   <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_ptr       <= w_ptr_nxt;
      r_steps     <= w_steps_nxt;
      r_rdy       <= w_rdy_nxt;
      r_out_valid <= w_valid_nxt;
      r_out_class <= w_class_nxt;
      r_out_steps <= w_osteps_nxt;
      r_out_err   <= w_err_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < FIDX_N; k++) r_feat[k] <= '0;
    end else if (w_feat_ld) begin
      for (int k = 0; k < FIDX_N; k++) r_feat[k] <= w_feat_in[k];
    end
  end

  // Reset leaves every node as a class-0 leaf.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int n = 0; n < N_NODES; n++) r_tbl[n] <= NODE_RST;
    end else if (w_tbl_we) begin
      r_tbl[cfg_addr] <= cfg_data;
    end
  end

  assign cfg_ready = r_rdy;
  assign in_ready  = r_rdy;
  assign out_valid = r_out_valid;
  assign out_class = r_out_class;
  assign out_steps = r_out_steps;
  assign out_err   = r_out_err;

endmodule

// File: tb/tb_dtree_seq_engine.sv
// Directed bench for dtree_seq_engine: reference tree walker feeds a result scoreboard.
module tb_dtree_seq_engine;

  localparam int unsigned N_FEAT    = 8;
  localparam int unsigned FEAT_W    = 8;
  localparam int unsigned CLASS_W   = 5;
  localparam int unsigned N_NODES   = 32;
  localparam int unsigned MAX_STEPS = 16;
  localparam int unsigned ADDR_W    = 5;
  localparam int unsigned NODE_W    = 25;
  localparam int unsigned STEP_W    = 5;

  typedef struct {
    logic [CLASS_W-1:0] cls;
    logic [STEP_W-1:0]  steps;
    logic               err;
  } exp_t;

  logic                     clk;
  logic                     rst_n;
  logic                     cfg_we;
  logic [ADDR_W-1:0]        cfg_addr;
  logic [NODE_W-1:0]        cfg_data;
  logic                     cfg_ready;
  logic                     in_valid;
  logic                     in_ready;
  logic [N_FEAT*FEAT_W-1:0] in_feat;
  logic                     out_valid;
  logic                     out_ready;
  logic [CLASS_W-1:0]       out_class;
  logic [STEP_W-1:0]        out_steps;
  logic                     out_err;

  // Second instance with only six features, for the bad-index case.
  logic                     d6_cfg_we;
  logic [NODE_W-1:0]        d6_cfg_data;
  logic                     d6_cfg_ready;
  logic                     d6_in_valid;
  logic                     d6_in_ready;
  logic [6*FEAT_W-1:0]      d6_in_feat;
  logic                     d6_out_valid;
  logic                     d6_out_ready;
  logic [CLASS_W-1:0]       d6_out_class;
  logic [STEP_W-1:0]        d6_out_steps;
  logic                     d6_out_err;

  int unsigned total = 0;
  int unsigned bad   = 0;
  exp_t        sb[$];
  logic [NODE_W-1:0] m_tbl [N_NODES];
  logic [NODE_W-1:0] g_wdata;

  dtree_seq_engine u_dut (
    .clk(clk), .rst_n(rst_n),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data), .cfg_ready(cfg_ready),
    .in_valid(in_valid), .in_ready(in_ready), .in_feat(in_feat),
    .out_valid(out_valid), .out_ready(out_ready), .out_class(out_class),
    .out_steps(out_steps), .out_err(out_err)
  );

  dtree_seq_engine #(.N_FEAT(6)) u_dut6 (
    .clk(clk), .rst_n(rst_n),
    .cfg_we(d6_cfg_we), .cfg_addr(5'd0), .cfg_data(d6_cfg_data), .cfg_ready(d6_cfg_ready),
    .in_valid(d6_in_valid), .in_ready(d6_in_ready), .in_feat(d6_in_feat),
    .out_valid(d6_out_valid), .out_ready(d6_out_ready), .out_class(d6_out_class),
    .out_steps(d6_out_steps), .out_err(d6_out_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic [NODE_W-1:0] mk_node(input logic leaf, input logic [2:0] fidx,
      input logic [2:0] sh, input logic [7:0] thr, input logic [4:0] l, input logic [4:0] r);
    return {leaf, fidx, sh, thr, l, r};
  endfunction

  function automatic logic [63:0] f6(input logic [7:0] v);
    return {8'h00, v, 48'h0};
  endfunction

  // Reference walk over the bench's copy of the node table.
  function automatic exp_t model(input logic [63:0] f);
    exp_t e;
    logic [ADDR_W-1:0] p;
    logic [NODE_W-1:0] n;
    logic [7:0] fv;
    p = '0;
    e.cls = '0; e.err = 1'b0; e.steps = '0;
    for (int s = 0; s < int'(MAX_STEPS); s++) begin
      n = m_tbl[p];
      if (n[24]) begin
        e.cls = n[14:10];
        e.steps = STEP_W'(s + 1);
        return e;
      end
      if (s == int'(MAX_STEPS) - 1) begin
        e.err = 1'b1;
        e.steps = STEP_W'(MAX_STEPS);
        return e;
      end
      fv = f[int'(n[23:21])*8 +: 8];
      p = ((fv >> n[20:18]) <= n[17:10]) ? n[9:5] : n[4:0];
    end
    return e;
  endfunction

  task automatic reset_model();
    for (int i = 0; i < int'(N_NODES); i++) m_tbl[i] = mk_node(1'b1, 3'd0, 3'd0, 8'd0, 5'd0, 5'd0);
  endtask

  task automatic cfg_write(input logic [4:0] a, input logic [NODE_W-1:0] d);
    @(negedge clk);
    cfg_we = 1'b1; cfg_addr = a; cfg_data = d;
    @(posedge clk); #1;
    cfg_we = 1'b0;
    m_tbl[a] = d;
  endtask

  // mode 0: plain; 1: write node0 with g_wdata alongside in_valid; 2: try writing node4 during WALK.
  task automatic run_inf(input string tag, input logic [63:0] f, input int hold, input int mode);
    exp_t e;
    int lat;
    @(negedge clk);
    check({tag, ":in_ready_idle"}, int'(in_ready), 1);
    in_feat = f; in_valid = 1'b1;
    if (mode == 1) begin
      cfg_we = 1'b1; cfg_addr = 5'd0; cfg_data = g_wdata;
      m_tbl[0] = g_wdata;
    end
    sb.push_back(model(f));
    @(posedge clk); #1;
    in_valid = 1'b0; cfg_we = 1'b0;
    if (mode == 2) begin
      cfg_we = 1'b1; cfg_addr = 5'd4; cfg_data = mk_node(1'b1, 3'd0, 3'd0, 8'd7, 5'd0, 5'd0);
    end
    lat = 0;
    while (out_valid !== 1'b1 && lat < 64) begin
      @(posedge clk); #1;
      lat++;
      cfg_we = 1'b0;
      if (lat == 1) begin
        check({tag, ":in_ready_busy"}, int'(in_ready), 0);
        check({tag, ":cfg_ready_busy"}, int'(cfg_ready), 0);
      end
    end
    e = sb.pop_front();
    check({tag, ":latency"}, lat, int'(e.steps));
    check({tag, ":class"}, int'(out_class), int'(e.cls));
    check({tag, ":steps"}, int'(out_steps), int'(e.steps));
    check({tag, ":err"}, int'(out_err), int'(e.err));
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check({tag, ":hold_valid"}, int'(out_valid), 1);
      check({tag, ":hold_class"}, int'(out_class), int'(e.cls));
      check({tag, ":hold_steps"}, int'(out_steps), int'(e.steps));
      check({tag, ":hold_in_ready"}, int'(in_ready), 0);
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({tag, ":valid_drop"}, int'(out_valid), 0);
    check({tag, ":in_ready_back"}, int'(in_ready), 1);
  endtask

  initial begin
    int lat;
    rst_n = 1'b0;
    cfg_we = 1'b0; cfg_addr = '0; cfg_data = '0;
    in_valid = 1'b0; in_feat = '0; out_ready = 1'b0;
    d6_cfg_we = 1'b0; d6_cfg_data = '0; d6_in_valid = 1'b0; d6_in_feat = '0; d6_out_ready = 1'b0;
    g_wdata = '0;
    reset_model();
    repeat (2) @(posedge clk);
    #1;
    check("rst:in_ready", int'(in_ready), 1);
    check("rst:cfg_ready", int'(cfg_ready), 1);
    check("rst:out_valid", int'(out_valid), 0);
    check("rst:out_class", int'(out_class), 0);
    check("rst:out_steps", int'(out_steps), 0);
    check("rst:out_err", int'(out_err), 0);
    @(negedge clk);
    rst_n = 1'b1;

    run_inf("unprog", 64'h0, 0, 0);
    check("unprog:direct_steps", int'(out_steps), 1);

    cfg_write(5'd0, mk_node(1'b0, 3'd6, 3'd6, 8'd0, 5'd1, 5'd2));
    cfg_write(5'd1, mk_node(1'b1, 3'd0, 3'd0, 8'd21, 5'd0, 5'd0));
    cfg_write(5'd2, mk_node(1'b0, 3'd6, 3'd2, 8'd0, 5'd3, 5'd4));
    cfg_write(5'd3, mk_node(1'b1, 3'd0, 3'd0, 8'd25, 5'd0, 5'd0));
    cfg_write(5'd4, mk_node(1'b1, 3'd0, 3'd0, 8'd19, 5'd0, 5'd0));
    run_inf("f30", f6(8'h30), 0, 0);
    check("f30:direct_class", int'(out_class), 21);
    run_inf("f42", f6(8'h42), 5, 0);
    check("f42:direct_class", int'(out_class), 19);
    run_inf("f41", f6(8'h41), 0, 0);
    run_inf("f02", f6(8'h02), 0, 0);

    cfg_write(5'd2, mk_node(1'b0, 3'd6, 3'd2, 8'h10, 5'd3, 5'd4));
    run_inf("f41_thr10", f6(8'h41), 0, 0);
    check("f41_thr10:direct_class", int'(out_class), 25);
    cfg_write(5'd2, mk_node(1'b0, 3'd6, 3'd2, 8'd0, 5'd3, 5'd4));

    run_inf("walk_write", f6(8'h42), 0, 2);
    run_inf("after_walk_write", f6(8'h42), 0, 0);
    check("after_walk_write:direct_class", int'(out_class), 19);

    cfg_write(5'd0, mk_node(1'b0, 3'd0, 3'd0, 8'hFF, 5'd0, 5'd0));
    run_inf("self_loop", 64'h0, 0, 0);
    check("self_loop:direct_steps", int'(out_steps), 16);

    g_wdata = mk_node(1'b1, 3'd0, 3'd0, 8'd9, 5'd0, 5'd0);
    run_inf("same_cycle_write", 64'h0, 0, 1);

    @(negedge clk);
    d6_cfg_we = 1'b1; d6_cfg_data = mk_node(1'b0, 3'd7, 3'd0, 8'd0, 5'd1, 5'd2);
    @(posedge clk); #1;
    d6_cfg_we = 1'b0;
    @(negedge clk);
    d6_in_valid = 1'b1;
    @(posedge clk); #1;
    d6_in_valid = 1'b0;
    lat = 0;
    while (d6_out_valid !== 1'b1 && lat < 64) begin
      @(posedge clk); #1;
      lat++;
    end
    check("badidx:latency", lat, 1);
    check("badidx:err", int'(d6_out_err), 1);
    check("badidx:steps", int'(d6_out_steps), 1);
    check("badidx:class", int'(d6_out_class), 0);
    @(negedge clk);
    d6_out_ready = 1'b1;
    @(posedge clk); #1;
    d6_out_ready = 1'b0;
    check("badidx:valid_drop", int'(d6_out_valid), 0);

    cfg_write(5'd0, mk_node(1'b0, 3'd0, 3'd0, 8'hFF, 5'd0, 5'd0));
    @(negedge clk);
    in_feat = '0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_walk:busy", int'(in_ready), 0);
    #2 rst_n = 1'b0;
    #1;
    check("rst_walk:out_valid", int'(out_valid), 0);
    check("rst_walk:in_ready", int'(in_ready), 1);
    check("rst_walk:cfg_ready", int'(cfg_ready), 1);
    @(negedge clk);
    rst_n = 1'b1;
    reset_model();
    run_inf("post_rst", 64'h0, 0, 0);
    check("post_rst:direct_class", int'(out_class), 0);

    check("sb_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
